if_fetch: RTL and testbench

Instruction-fetch stage feeding the decode stage. Holds the fetch PC, runs a request/acknowledge handshake with the instruction ROM, buffers returned words with their PCs in a small FIFO, and presents one `{pc, inst}` pair per cycle to the IF/ID boundary. It supports downstream stall and redirect (flush to a new PC); an in-flight ROM request is never aborted, and its data is discarded instead.

---
 rtl/if_fetch.sv | 143 ++++++++++++++
 tb/tb_if_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC, single-outstanding ROM handshake,
// small {pc, inst} buffer presenting its head to the IF/ID boundary.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  // WAIT keeps the returned word, DROP throws it away (stale after a flush)
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  entry_t            mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              pop, push;
  logic [CW:0]       occ;
  logic              room_idle, room_next;
  logic [ADDR_W-1:0] target;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign target       = {new_pc_i[ADDR_W-1:2], 2'b00};
  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o && !stall_i && !flush_i;
  assign push         = (state == WAIT) && rom_ack_i && !flush_i;

  // occupancy once this cycle's pop has left; decides whether to keep fetching
  assign occ       = {1'b0, count} - (CW+1)'(pop);
  assign room_idle = occ < DEPTH_C;
  assign room_next = (occ + (CW+1)'(1)) < DEPTH_C;

  // head is presented straight from the buffer registers, zeros when empty
  assign pc_o   = inst_valid_o ? mem[head].pc   : '0;
  assign inst_o = inst_valid_o ? mem[head].inst : '0;

  // buffer pointers and occupancy; flush empties the buffer outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // buffer storage, data path only (validity lives in count)
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: rom_addr_o, inst: rom_data_i};
  end

  // fetch FSM with registered ROM request/address; a request once issued
  // is always held until acked, even across a redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= {RESET_PC[ADDR_W-1:2], 2'b00};
      rom_req_o  <= 1'b0;
      rom_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            fetch_pc   <= target;
            state      <= WAIT;
            rom_req_o  <= 1'b1;
            rom_addr_o <= target;
          end else if (room_idle) begin
            state      <= WAIT;
            rom_req_o  <= 1'b1;
            rom_addr_o <= fetch_pc;
          end
        end
        WAIT: begin
          if (flush_i) begin
            fetch_pc <= target;
            // acked word is stale: reissue at once; otherwise wait it out
            if (rom_ack_i) rom_addr_o <= target;
            else           state      <= DROP;
          end else if (rom_ack_i) begin
            fetch_pc <= rom_addr_o + STEP;
            if (room_next) begin
              rom_addr_o <= rom_addr_o + STEP;
            end else begin
              state     <= IDLE;
              rom_req_o <= 1'b0;
            end
          end
        end
        DROP: begin
          // fetch_pc holds the redirect target until the stale ack returns;
          // a flush here only retargets (the held request gets a stale ack)
          if (flush_i) begin
            fetch_pc <= target;
          end else if (rom_ack_i) begin
            state      <= WAIT;
            rom_addr_o <= fetch_pc;
          end
        end
        default: begin
          state     <= IDLE;
          rom_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: ROM model with programmable ack latency,
// pop-stream checker, and cycle-exact checks on reset, stall, flush, wrap.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic [31:0] new_pc_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o;

  int          checks = 0;
  int          fails  = 0;
  int          pops   = 0;
  logic [31:0] exp_pc = 32'h0;

  // ROM model controls
  int          lat  = 0;
  logic        hold = 1'b0;
  int          wcnt = 0;

  if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .new_pc_i(new_pc_i), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .pc_o(pc_o),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ROM: acks a request after lat cycles unless held off
  assign rom_ack_i  = rom_req_o && (wcnt >= lat) && !hold;
  assign rom_data_i = rom_ack_i ? rom_word(rom_addr_o) : 32'h0;

  always @(posedge clk) begin
    if (!rom_req_o || rom_ack_i) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  // pop stream must be the contiguous PC sequence from the last redirect
  always @(posedge clk) begin
    if (!rst) exp_pc = 32'h0;
    else if (flush_i) exp_pc = {new_pc_i[31:2], 2'b00};
    else if (inst_valid_o && !stall_i) begin
      chk("pop_pc", pc_o, exp_pc);
      chk("pop_inst", inst_o, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (rst && dut.push) chk("push_room", 64'(dut.count < 2'd2), 1);
  end

  initial begin
    logic [31:0] hp, prev_addr;
    logic        prev_wait, seen;
    int          p0;

    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_req", rom_req_o, 0);
    chk("rst_addr", rom_addr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_valid", inst_valid_o, 0);

    // free run from RESET_PC
    rst = 1'b1;
    @(negedge clk);
    chk("e1_req", rom_req_o, 1);
    chk("e1_addr", rom_addr_o, 32'h0);
    chk("e1_valid", inst_valid_o, 0);
    @(negedge clk);
    chk("e2_valid", inst_valid_o, 1);
    chk("e2_pc", pc_o, 32'h0);
    chk("e2_inst", inst_o, rom_word(32'h0));
    chk("e2_addr", rom_addr_o, 32'h4);
    @(negedge clk);
    chk("e3_pc", pc_o, 32'h4);
    chk("e3_addr", rom_addr_o, 32'h8);
    repeat (3) @(negedge clk);

    // stall: buffer fills, request drops, head frozen
    hp = exp_pc;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", pc_o, hp);
      chk("stall_inst", inst_o, rom_word(hp));
      chk("stall_req", rom_req_o, 0);
    end
    stall_i = 1'b0;
    repeat (4) @(negedge clk);

    // slow ROM: one word per 4 cycles, address held while waiting
    lat  = 3;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rom_ack_i;
    end
    chk("ack_seen", seen, 1);
    p0 = pops;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    repeat (16) begin
      @(negedge clk);
      if (prev_wait) chk("addr_hold", rom_addr_o, prev_addr);
      prev_wait = rom_req_o && !rom_ack_i;
      prev_addr = rom_addr_o;
    end
    chk("slow_rate", pops - p0, 4);

    // flush while 0x8 is pending and its ack is late -> DROP
    lat = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("d_addr8", rom_addr_o, 32'h8);
    hold = 1'b1;
    flush_i = 1'b1; new_pc_i = 32'h100;
    @(negedge clk);
    flush_i = 1'b0;
    chk("d_valid", inst_valid_o, 0);
    chk("d_req", rom_req_o, 1);
    chk("d_hold8", rom_addr_o, 32'h8);
    chk("d_state", dut.state, 2);
    @(negedge clk);
    chk("d_hold8b", rom_addr_o, 32'h8);
    hold = 1'b0;
    @(negedge clk);
    chk("d_valid2", inst_valid_o, 0);
    chk("d_addr100", rom_addr_o, 32'h100);
    chk("d_req2", rom_req_o, 1);
    @(negedge clk);
    chk("d_valid3", inst_valid_o, 1);
    chk("d_pc100", pc_o, 32'h100);
    chk("d_inst100", inst_o, rom_word(32'h100));
    repeat (2) @(negedge clk);

    // flush together with stall, a valid head and an ack
    chk("c_valid_pre", inst_valid_o, 1);
    chk("c_ack_pre", rom_ack_i, 1);
    stall_i = 1'b1; flush_i = 1'b1; new_pc_i = 32'h200;
    @(negedge clk);
    stall_i = 1'b0; flush_i = 1'b0;
    chk("c_valid", inst_valid_o, 0);
    chk("c_req", rom_req_o, 1);
    chk("c_addr", rom_addr_o, 32'h200);
    @(negedge clk);
    chk("c_pc", pc_o, 32'h200);
    repeat (2) @(negedge clk);

    // PC wrap past all-ones
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    flush_i = 1'b0;
    chk("w_addr", rom_addr_o, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("w_pc0", pc_o, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("w_pc1", pc_o, 32'h0);
    @(negedge clk);
    chk("w_pc2", pc_o, 32'h4);

    // async reset mid-WAIT
    lat = 3;
    repeat (2) @(negedge clk);
    chk("r_req_pre", rom_req_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("r_req", rom_req_o, 0);
    chk("r_addr", rom_addr_o, 0);
    chk("r_pc", pc_o, 0);
    chk("r_inst", inst_o, 0);
    chk("r_valid", inst_valid_o, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
